// File: rtl/fetch_sequencer.sv
// Fetch control FSM: steers the PC register, issues one imem request
// at a time and holds the fetched instruction until decode takes it.
module fetch_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc,
    output logic            pc_inc,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_load_value,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            stall,
    output logic            fault
);

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        DRAIN,
        HOLD,
        FAULT
    } state_t;

    state_t state;
    logic   misaligned;

    assign misaligned = pc[1:0] != 2'b00;
    assign imem_addr  = pc;

    always_comb begin
        pc_inc         = 1'b0;
        pc_load        = 1'b0;
        pc_load_value  = redirect_target;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        case (state)
            BOOT: begin
                // PC register has no reset, so keep loading it while in reset
                pc_load       = 1'b1;
                pc_load_value = RESET_PC;
            end
            REQ: begin
                if (!misaligned) begin
                    if (redirect_valid) begin
                        pc_load = 1'b1;
                    end else if (!stall) begin
                        imem_req_valid = 1'b1;
                    end
                end
            end
            WAIT, DRAIN: begin
                pc_load = redirect_valid;
            end
            HOLD: begin
                inst_valid = !redirect_valid;
                pc_load    = redirect_valid;
                pc_inc     = !redirect_valid && inst_ready;
            end
            default: begin
                pc_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= BOOT;
            inst_data <= '0;
            inst_pc   <= '0;
            fault     <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= REQ;
                end
                REQ: begin
                    if (misaligned) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else if (!redirect_valid && !stall &&
                                 imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        state <= imem_rsp_valid ? REQ : DRAIN;
                    end else if (imem_rsp_valid) begin
                        inst_data <= imem_rsp_data;
                        inst_pc   <= pc;
                        state     <= HOLD;
                    end
                end
                DRAIN: begin
                    // stale response is discarded; redirects here only reload pc
                    if (imem_rsp_valid) begin
                        state <= REQ;
                    end
                end
                HOLD: begin
                    if (redirect_valid || inst_ready) begin
                        state <= REQ;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed test-plan steps, then random traffic
// checked against a flag-based behavioural model of the fetch protocol.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] pc;
    logic        pc_inc;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall;
    logic        fault;

    int errors = 0;
    int checks = 0;

    bit          m_boot, m_fault, m_out, m_drop, m_held;
    logic [31:0] m_data, m_ipc, pc_s;

    fetch_sequencer #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .pc              (pc),
        .pc_inc          (pc_inc),
        .pc_load         (pc_load),
        .pc_load_value   (pc_load_value),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .fault           (fault)
    );

    always #5 clock = ~clock;

    // the PC register this block drives
    initial pc = 32'h0;
    always @(posedge clock) begin
        if (pc_load) pc <= pc_load_value;
        else if (pc_inc) pc <= pc + 32'd4;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_fault = 1'b0;
        m_out   = 1'b0;
        m_drop  = 1'b0;
        m_held  = 1'b0;
        m_data  = 32'h0;
        m_ipc   = 32'h0;
    endtask

    // check all outputs against the model in the middle of the cycle
    task automatic sample();
        logic e_load, e_inc, e_req, e_iv;
        logic [31:0] e_val;
        @(negedge clock);
        pc_s   = pc;
        e_load = 1'b0;
        e_inc  = 1'b0;
        e_req  = 1'b0;
        e_iv   = 1'b0;
        e_val  = redirect_target;
        if (!reset_n || m_boot) begin
            e_load = 1'b1;
            e_val  = RST_PC;
        end else if (m_fault) begin
            e_load = 1'b0;
        end else if (m_held) begin
            e_iv   = !redirect_valid;
            e_load = redirect_valid;
            e_inc  = !redirect_valid && inst_ready;
        end else if (m_out) begin
            e_load = redirect_valid;
        end else if (pc_s[1:0] == 2'b00) begin
            e_load = redirect_valid;
            e_req  = !redirect_valid && !stall;
        end
        chk1("pc_load", pc_load, e_load);
        if (e_load) chk32("pc_load_value", pc_load_value, e_val);
        chk1("pc_inc", pc_inc, e_inc);
        chk1("inc_load_excl", pc_inc & pc_load, 1'b0);
        chk1("imem_req_valid", imem_req_valid, e_req);
        chk32("imem_addr", imem_addr, pc_s);
        chk1("inst_valid", inst_valid, e_iv);
        chk32("inst_data", inst_data, m_data);
        chk32("inst_pc", inst_pc, m_ipc);
        chk1("fault", fault, m_fault);
    endtask

    // advance the model across the clock edge using this cycle's inputs
    task automatic advance();
        @(posedge clock);
        if (!reset_n) begin
            model_reset();
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_fault) begin
            m_fault = 1'b1;
        end else if (m_held) begin
            if (redirect_valid || inst_ready) m_held = 1'b0;
        end else if (m_out) begin
            if (redirect_valid) begin
                if (imem_rsp_valid) begin
                    m_out  = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end else if (imem_rsp_valid) begin
                m_out = 1'b0;
                if (!m_drop) begin
                    m_held = 1'b1;
                    m_data = imem_rsp_data;
                    m_ipc  = pc_s;
                end
                m_drop = 1'b0;
            end
        end else if (pc_s[1:0] != 2'b00) begin
            m_fault = 1'b1;
        end else if (!redirect_valid && !stall && imem_req_ready) begin
            m_out = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        stall           = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_reset();

        // reset held for three cycles, PC loaded throughout
        for (int i = 0; i < 3; i++) begin
            sample();
            chk1("rst_pc_load", pc_load, 1'b1);
            chk32("rst_load_value", pc_load_value, RST_PC);
            advance();
        end
        reset_n = 1'b1;
        sample();
        advance();
        imem_req_ready = 1'b1;
        sample();
        chk1("first_req", imem_req_valid, 1'b1);
        chk32("first_addr", imem_addr, 32'h100);
        advance();

        // straight-line fetch
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00A0_0093;
        sample();
        advance();
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b1;
        sample();
        chk1("sl_inst_valid", inst_valid, 1'b1);
        chk32("sl_inst_data", inst_data, 32'h00A0_0093);
        chk32("sl_inst_pc", inst_pc, 32'h100);
        chk1("sl_pc_inc", pc_inc, 1'b1);
        advance();
        inst_ready = 1'b0;
        sample();
        chk1("sl_inc_once", pc_inc, 1'b0);
        chk32("sl_next_addr", imem_addr, 32'h104);

        // stall for four cycles in REQ
        stall          = 1'b1;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            advance();
            sample();
            chk1("stall_no_req", imem_req_valid, 1'b0);
        end
        advance();
        stall = 1'b0;
        sample();
        chk1("stall_release_req", imem_req_valid, 1'b1);
        chk32("stall_addr", imem_addr, 32'h104);
        advance();

        // redirect while waiting for the response
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        sample();
        chk1("wr_pc_load", pc_load, 1'b1);
        chk32("wr_target", pc_load_value, 32'h200);
        advance();
        redirect_valid = 1'b0;
        sample();
        chk1("wr_drain_no_load", pc_load, 1'b0);
        chk1("wr_drain_no_req", imem_req_valid, 1'b0);
        advance();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_0013;
        sample();
        chk1("wr_drop_valid", inst_valid, 1'b0);
        advance();
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        sample();
        chk1("wr_drop_after", inst_valid, 1'b0);
        chk1("wr_req", imem_req_valid, 1'b1);
        chk32("wr_addr", imem_addr, 32'h200);
        advance();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0513;
        sample();
        advance();

        // redirect in HOLD together with inst_ready
        imem_rsp_valid  = 1'b0;
        inst_ready      = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        sample();
        chk1("hr_inst_valid", inst_valid, 1'b0);
        chk1("hr_pc_inc", pc_inc, 1'b0);
        chk1("hr_pc_load", pc_load, 1'b1);
        chk32("hr_target", pc_load_value, 32'h300);
        advance();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        sample();
        chk1("hr_req", imem_req_valid, 1'b1);
        chk32("hr_addr", imem_addr, 32'h300);
        advance();

        // misaligned redirect, then asynchronous reset
        redirect_valid  = 1'b1;
        redirect_target = 32'h202;
        sample();
        advance();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        sample();
        chk1("mis_no_req", imem_req_valid, 1'b0);
        advance();
        sample();
        chk1("mis_fault", fault, 1'b1);
        chk1("mis_fault_no_req", imem_req_valid, 1'b0);
        advance();
        #3;
        reset_n = 1'b0;
        #1;
        chk1("async_fault_clear", fault, 1'b0);
        chk1("async_boot_load", pc_load, 1'b1);
        chk32("async_boot_value", pc_load_value, RST_PC);
        model_reset();
        advance();
        sample();
        advance();
        reset_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (m_fault) begin
                reset_n = 1'b0;
                model_reset();
                sample();
                advance();
                reset_n = 1'b1;
            end
            redirect_valid  = ($urandom % 6) == 0;
            redirect_target = $urandom & 32'hFFFF_FFFC;
            if (($urandom % 40) == 0) redirect_target[1] = 1'b1;
            stall          = ($urandom % 4) == 0;
            imem_req_ready = ($urandom % 2) == 0;
            imem_rsp_valid = m_out && (($urandom % 2) == 0);
            imem_rsp_data  = $urandom;
            inst_ready     = ($urandom % 2) == 0;
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch control FSM for the core's program counter. Drives the `inc`/`load`/`in` controls of the PC register and issues one instruction-memory request at a time. Holds each fetched instruction for decode, and applies branch/jump redirects by loading the PC and discarding any in-flight fetch. It sits between the PC register, the instruction memory port and the decode stage.

## Interface

Parameters:
- `XLEN`, 32: address/PC width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `pc`  in  XLEN: current value of the PC register.
- `pc_inc`  out  1: PC register `inc` strobe (+4).
- `pc_load`  out  1: PC register `load` strobe.
- `pc_load_value`  out  XLEN: PC register `in` value.
- `imem_req_valid`  out  1: fetch request.
- `imem_req_ready`  in  1: memory accepts request this cycle.
- `imem_addr`  out  XLEN: fetch address, always equal to `pc`.
- `imem_rsp_valid`  in  1: response data valid.
- `imem_rsp_data`  in  32: fetched instruction.
- `inst_valid`  out  1: instruction available to decode.
- `inst_ready`  in  1: decode accepts instruction.
- `inst_data`  out  32: held instruction.
- `inst_pc`  out  XLEN: address of held instruction.
- `redirect_valid`  in  1: branch/jump taken.
- `redirect_target`  in  XLEN: new PC.
- `stall`  in  1: suppress new fetch requests.
- `fault`  out  1: sticky misaligned-fetch flag.

## Operation

States: BOOT, REQ, WAIT, DRAIN, HOLD, FAULT. `reset_n` low forces BOOT asynchronously. Registered outputs clear: `inst_data`=0, `inst_pc`=0, `fault`=0.

- **BOOT:** `pc_load`=1, `pc_load_value`=RESET_PC. This holds for the whole time reset is asserted, because the PC register has no reset of its own. Next state: REQ.
- **REQ:**
  - If `pc[1:0]`≠0: go to FAULT; no request is issued.
  - Else if `redirect_valid`: `pc_load`=1 with `redirect_target`; stay in REQ; no request.
  - Else if `stall`: no request; stay in REQ.
  - Otherwise: `imem_req_valid`=1. If `imem_req_ready`, go to WAIT.
- **WAIT:**
  - `redirect_valid` with `imem_rsp_valid`: `pc_load`=1; drop the response; go to REQ.
  - `redirect_valid` without `imem_rsp_valid`: `pc_load`=1; go to DRAIN.
  - `imem_rsp_valid` without redirect: capture `inst_data`←`imem_rsp_data` and `inst_pc`←`pc`; go to HOLD.
- **DRAIN:** wait for `imem_rsp_valid`, drop it, then go to REQ. A further redirect here reloads the PC (latest wins) and stays in DRAIN until the response arrives.
- **HOLD:** `inst_valid` = !`redirect_valid`.
  - A redirect wins: `pc_load`=1, the instruction is dropped, go to REQ.
  - Else if `inst_ready`: `pc_inc`=1; go to REQ.
- **FAULT:** all strobes are 0 and `fault`=1. Only reset exits this state.

Invariants:
- `pc_inc` and `pc_load` are never asserted in the same cycle.
- At most one memory request is outstanding.
- `imem_req_valid` may drop before acceptance when `stall` or `redirect_valid` is asserted. The memory treats each cycle's valid independently.
- Outputs `pc_load`, `pc_load_value`, `pc_inc`, `imem_req_valid` and `inst_valid` are combinational from the state and inputs (Mealy).
- `inst_data` and `inst_pc` are stable throughout HOLD.

## Timing

- The PC register updates on the same edge that samples `pc_inc`/`pc_load`, so the new `pc` is visible one cycle later, in REQ.
- Reset release to first request: 1 cycle (BOOT→REQ).
- Earliest response is the cycle after acceptance (in WAIT).
- Best-case instruction: request accepted in cycle n, response in n+1, `inst_valid` in n+2, next request in n+3.
- Throughput is at most one instruction per 3 cycles.

## Test plan

- **Reset and first fetch:** hold `reset_n` low 3 cycles with RESET_PC=32'h100, then release. Required: `pc_load`=1 throughout reset; `imem_req_valid`=1 with `imem_addr`=32'h100 one cycle after release.
- **Straight-line fetch:** ready=1; response 32'h00A00093 arrives 1 cycle after acceptance; `inst_ready`=1. Required: `inst_valid` with `inst_data`=32'h00A00093 and `inst_pc`=32'h100; `pc_inc` pulses once; next `imem_addr`=32'h104.
- **Stall:** assert `stall` for 4 cycles in REQ. Required: `imem_req_valid`=0 for those 4 cycles; request issued on the first cycle after `stall` drops, with the address unchanged.
- **Redirect in WAIT:** redirect to 32'h200 before the response arrives. Required: one `pc_load` cycle; state DRAIN; the response is dropped (no `inst_valid`); the next request is at 32'h200.
- **Redirect in HOLD together with `inst_ready`:** Required: `inst_valid`=0 that cycle; `pc_inc`=0 and `pc_load`=1; the next request goes to the target address.
- **Misaligned redirect and async reset:** redirect to 32'h202. Required: `fault`=1 and no request is issued. Then assert `reset_n` low mid-cycle; required: `fault` clears immediately and the sequencer returns to BOOT.
